// File: rtl/life_sched_pkg.sv
// Shared types and helpers for the life_sched trial scheduler / result arbiter.
`default_nettype none
package life_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } sched_state_e;

  typedef enum logic [1:0] {
    CORE_FREE    = 2'd0,
    CORE_RUNNING = 2'd1,
    CORE_HOLD    = 2'd2
  } core_state_e;

  localparam int unsigned CNT_W = 32;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (v > (32'd1 << i)) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/life_sched_rr_arb.sv
// Rotating-priority arbiter: grants the first request at or after ptr, wrapping at N.
`default_nettype none
module rr_arb
  import life_sched_pkg::*;
#(
  parameter int N = 4,
  parameter int W = (N > 1) ? int'(clog2(N)) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx
);

  always_comb begin
    int   idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = W'(idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/life_sched.sv
// Trial scheduler: dispatches single-trial jobs round-robin to NCORE search cores
// and forwards hit results one at a time to the UART transmitter.
`default_nettype none
module life_sched
  import life_sched_pkg::*;
#(
  parameter int NCORE = 4,
  parameter int DW    = 432,
  parameter int IW    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [31:0]         num_init,
  output logic [NCORE-1:0]    core_start,
  input  logic [NCORE-1:0]    core_done,
  input  logic [NCORE-1:0]    core_hit,
  input  logic [NCORE*DW-1:0] core_data,
  output logic [NCORE-1:0]    core_ack,
  output logic                core_clear,
  output logic                tx_valid,
  output logic [DW-1:0]       tx_data,
  output logic [IW-1:0]       tx_id,
  input  logic                tx_ready,
  output logic                busy,
  output logic                done,
  output logic [31:0]         trials_done
);

  sched_state_e      state_q, state_d;
  core_state_e       cst_q [NCORE];
  core_state_e       cst_d [NCORE];
  logic [CNT_W-1:0]  left_q, left_d;
  logic [CNT_W-1:0]  trials_q, trials_d;
  logic [IW-1:0]     disp_ptr_q, disp_ptr_d;
  logic [IW-1:0]     res_ptr_q, res_ptr_d;
  logic [NCORE-1:0]  core_start_q, core_start_d;
  logic [NCORE-1:0]  core_ack_q, core_ack_d;
  logic              core_clear_q, core_clear_d;
  logic              abort_q;
  logic              tx_valid_q, tx_valid_d;
  logic [DW-1:0]     tx_data_q, tx_data_d;
  logic [IW-1:0]     tx_id_q, tx_id_d;
  logic              done_q, done_d;

  logic [NCORE-1:0]  free_mask, run_mask, hold_mask;
  logic [NCORE-1:0]  disp_req, disp_gnt, res_req, res_gnt;
  logic [IW-1:0]     disp_idx, res_idx;
  logic              all_free, out_free;
  logic [CNT_W-1:0]  done_cnt;
  logic [CNT_W:0]    trials_sum;

  function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] i);
    return (i == IW'(NCORE - 1)) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    free_mask = '0;
    run_mask  = '0;
    hold_mask = '0;
    done_cnt  = '0;
    for (int i = 0; i < NCORE; i++) begin
      free_mask[i] = (cst_q[i] == CORE_FREE);
      run_mask[i]  = (cst_q[i] == CORE_RUNNING);
      hold_mask[i] = (cst_q[i] == CORE_HOLD);
      if ((cst_q[i] == CORE_RUNNING) && core_done[i]) done_cnt = done_cnt + 1'b1;
    end
  end

  assign all_free   = &free_mask;
  // The output register may be refilled in the same cycle it is being drained.
  assign out_free   = !tx_valid_q || tx_ready;
  assign disp_req   = ((state_q == S_RUN) && (left_q != '0)) ? free_mask : '0;
  assign res_req    = out_free ? hold_mask : '0;
  assign trials_sum = {1'b0, trials_q} + {1'b0, done_cnt};

  rr_arb #(.N(NCORE), .W(IW)) u_disp_arb (
    .req     (disp_req),
    .ptr     (disp_ptr_q),
    .gnt     (disp_gnt),
    .gnt_idx (disp_idx)
  );

  rr_arb #(.N(NCORE), .W(IW)) u_res_arb (
    .req     (res_req),
    .ptr     (res_ptr_q),
    .gnt     (res_gnt),
    .gnt_idx (res_idx)
  );

  always_comb begin
    state_d      = state_q;
    left_d       = left_q;
    trials_d     = trials_q;
    disp_ptr_d   = disp_ptr_q;
    res_ptr_d    = res_ptr_q;
    cst_d        = cst_q;
    core_start_d = '0;
    core_ack_d   = '0;
    done_d       = 1'b0;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    tx_id_d      = tx_id_q;
    core_clear_d = abort && !abort_q;

    if (abort) begin
      state_d    = S_IDLE;
      tx_valid_d = 1'b0;
      tx_data_d  = '0;
      tx_id_d    = '0;
      for (int i = 0; i < NCORE; i++) cst_d[i] = CORE_FREE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            left_d     = num_init;
            trials_d   = '0;
            disp_ptr_d = '0;
            res_ptr_d  = '0;
            state_d    = S_RUN;
          end
        end
        S_RUN: begin
          if (left_q == '0) begin
            state_d = S_DRAIN;
          end else if (disp_gnt != '0) begin
            core_start_d = disp_gnt;
            left_d       = left_q - 1'b1;
            disp_ptr_d   = inc_wrap(disp_idx);
          end
        end
        S_DRAIN: begin
          if (all_free && !tx_valid_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (state_q != S_IDLE) begin
        trials_d = trials_sum[CNT_W] ? '1 : trials_sum[CNT_W-1:0];
        if (tx_valid_q && tx_ready) tx_valid_d = 1'b0;
        if (res_gnt != '0) begin
          tx_valid_d = 1'b1;
          tx_id_d    = res_idx;
          core_ack_d = res_gnt;
          res_ptr_d  = inc_wrap(res_idx);
        end
        // Dispatch needs FREE, completion RUNNING, ack HOLD: at most one applies per core.
        for (int i = 0; i < NCORE; i++) begin
          if (disp_gnt[i]) begin
            cst_d[i] = CORE_RUNNING;
          end else if (run_mask[i] && core_done[i]) begin
            cst_d[i] = core_hit[i] ? CORE_HOLD : CORE_FREE;
          end else if (res_gnt[i]) begin
            cst_d[i]  = CORE_FREE;
            tx_data_d = core_data[i*DW +: DW];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      left_q       <= '0;
      trials_q     <= '0;
      disp_ptr_q   <= '0;
      res_ptr_q    <= '0;
      core_start_q <= '0;
      core_ack_q   <= '0;
      core_clear_q <= 1'b0;
      abort_q      <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      tx_id_q      <= '0;
      done_q       <= 1'b0;
      for (int i = 0; i < NCORE; i++) cst_q[i] <= CORE_FREE;
    end else begin
      state_q      <= state_d;
      left_q       <= left_d;
      trials_q     <= trials_d;
      disp_ptr_q   <= disp_ptr_d;
      res_ptr_q    <= res_ptr_d;
      core_start_q <= core_start_d;
      core_ack_q   <= core_ack_d;
      core_clear_q <= core_clear_d;
      abort_q      <= abort;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      tx_id_q      <= tx_id_d;
      done_q       <= done_d;
      for (int i = 0; i < NCORE; i++) cst_q[i] <= cst_d[i];
    end
  end

  assign core_start  = core_start_q;
  assign core_ack    = core_ack_q;
  assign core_clear  = core_clear_q;
  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign tx_id       = tx_id_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign trials_done = trials_q;

endmodule
`default_nettype wire

// File: tb/tb_life_sched.sv
// Directed bench for life_sched: behavioural core models with per-core latency/hit settings.
`default_nettype none
module tb_life_sched;

  localparam int NC = 4;
  localparam int DW = 24;
  localparam int IW = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic [31:0]       num_init;
  logic [NC-1:0]     core_start;
  logic [NC-1:0]     core_done;
  logic [NC-1:0]     core_hit;
  logic [NC*DW-1:0]  core_data;
  logic [NC-1:0]     core_ack;
  logic              core_clear;
  logic              tx_valid;
  logic [DW-1:0]     tx_data;
  logic [IW-1:0]     tx_id;
  logic              tx_ready;
  logic              busy;
  logic              done;
  logic [31:0]       trials_done;

  always #5 clk = ~clk;

  life_sched #(.NCORE(NC), .DW(DW), .IW(IW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .num_init    (num_init),
    .core_start  (core_start),
    .core_done   (core_done),
    .core_hit    (core_hit),
    .core_data   (core_data),
    .core_ack    (core_ack),
    .core_clear  (core_clear),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_id       (tx_id),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .done        (done),
    .trials_done (trials_done)
  );

  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            n_done = 0;
  int            timer [NC];
  int            lat [NC];
  logic [NC-1:0] hit_cfg;
  logic [NC-1:0] inj_done;
  int            start_log[$];
  int            ack_log[$];
  int            ack_cyc[$];
  int            hs_ids[$];
  logic          prev_valid;
  logic [IW-1:0] prev_id;
  logic          saw_valid;
  int            d0;

  function automatic logic [DW-1:0] pat(input int i);
    return 24'h5A0000 + DW'(i) * 24'h000111;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: observe registered outputs at the falling edge, then drive the core models.
  task automatic step();
    logic [NC-1:0] newst;
    @(negedge clk);
    cyc++;
    newst = '0;
    if (prev_valid && tx_ready) hs_ids.push_back(int'(prev_id));
    prev_valid = tx_valid;
    prev_id    = tx_id;
    if (core_clear) for (int i = 0; i < NC; i++) timer[i] = 0;
    if (done) n_done++;
    if (tx_valid) saw_valid = 1'b1;
    if (core_start != '0) check("start_onehot", 64'($countones(core_start)), 64'd1);
    for (int i = 0; i < NC; i++) begin
      if (core_start[i]) begin
        start_log.push_back(i);
        newst[i] = 1'b1;
      end
    end
    if (core_ack != '0) begin
      check("ack_onehot", 64'($countones(core_ack)), 64'd1);
      for (int i = 0; i < NC; i++) begin
        if (core_ack[i]) begin
          ack_log.push_back(i);
          ack_cyc.push_back(cyc);
          check("ack_id", 64'(tx_id), 64'(i));
          check("ack_data", 64'(tx_data), 64'(pat(i)));
          check("ack_valid", 64'(tx_valid), 64'd1);
        end
      end
    end
    core_done = inj_done;
    core_hit  = '0;
    inj_done  = '0;
    for (int i = 0; i < NC; i++) begin
      if (timer[i] > 0) begin
        timer[i]--;
        if (timer[i] == 0) begin
          core_done[i] = 1'b1;
          core_hit[i]  = hit_cfg[i];
        end
      end
      if (newst[i]) timer[i] = lat[i];
    end
  endtask

  task automatic kick(input int n);
    num_init = n;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int base;
    int k;
    base = n_done;
    k    = 0;
    while (n_done == base && k < maxc) begin
      step();
      k++;
    end
    check({"done_seen_", tag}, 64'(n_done > base), 64'd1);
  endtask

  task automatic new_test(input int l0, input int l1, input int l2, input int l3,
                          input logic [NC-1:0] hits, input logic rdy);
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
    hit_cfg   = hits;
    tx_ready  = rdy;
    saw_valid = 1'b0;
    start_log.delete();
    ack_log.delete();
    ack_cyc.delete();
    hs_ids.delete();
    d0 = n_done;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; num_init = '0;
    core_done = '0; core_hit = '0; tx_ready = 1'b0; inj_done = '0;
    hit_cfg = '0; prev_valid = 1'b0; prev_id = '0; saw_valid = 1'b0;
    for (int i = 0; i < NC; i++) begin
      timer[i] = 0;
      lat[i]   = 1;
      core_data[i*DW +: DW] = pat(i);
    end
    repeat (3) @(negedge clk);
    check("rst_core_start", 64'(core_start), 64'd0);
    check("rst_core_ack", 64'(core_ack), 64'd0);
    check("rst_core_clear", 64'(core_clear), 64'd0);
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    check("rst_tx_id", 64'(tx_id), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_trials", 64'(trials_done), 64'd0);
    reset = 1'b1;
    step();
    step();

    // Ten no-hit trials, 5-cycle latency: strict round-robin dispatch.
    new_test(5, 5, 5, 5, 4'b0000, 1'b1);
    kick(10);
    check("t1_busy", 64'(busy), 64'd1);
    wait_done("t1", 200);
    check("t1_nstart", 64'(start_log.size()), 64'd10);
    for (int k = 0; k < start_log.size(); k++) check("t1_order", 64'(start_log[k]), 64'(k % 4));
    check("t1_trials", 64'(trials_done), 64'd10);
    check("t1_busy_end", 64'(busy), 64'd0);
    repeat (3) step();
    check("t1_ndone", 64'(n_done - d0), 64'd1);
    check("t1_no_valid", 64'(saw_valid), 64'd0);

    // Zero trials: done exactly two cycles after start.
    new_test(5, 5, 5, 5, 4'b0000, 1'b1);
    kick(0);
    check("t2_busy1", 64'(busy), 64'd1);
    check("t2_done1", 64'(done), 64'd0);
    step();
    check("t2_done2", 64'(done), 64'd0);
    step();
    check("t2_done3", 64'(done), 64'd1);
    check("t2_busy3", 64'(busy), 64'd0);
    check("t2_nstart", 64'(start_log.size()), 64'd0);
    check("t2_trials", 64'(trials_done), 64'd0);

    // Cores 1 and 3 hit on the same cycle: results on consecutive cycles, id 1 first.
    new_test(3, 6, 3, 4, 4'b1010, 1'b1);
    kick(4);
    wait_done("t3", 60);
    check("t3_nack", 64'(ack_log.size()), 64'd2);
    check("t3_ack0", 64'(ack_log[0]), 64'd1);
    check("t3_ack1", 64'(ack_log[1]), 64'd3);
    check("t3_b2b", 64'(ack_cyc[1] - ack_cyc[0]), 64'd1);
    check("t3_nhs", 64'(hs_ids.size()), 64'd2);
    check("t3_trials", 64'(trials_done), 64'd4);

    // Three results held back by tx_ready low for 20 cycles.
    new_test(3, 3, 3, 3, 4'b0111, 1'b0);
    kick(3);
    begin
      int k = 0;
      while (ack_log.size() == 0 && k < 30) begin
        step();
        k++;
      end
    end
    check("t4_first_ack", 64'(ack_log.size()), 64'd1);
    repeat (20) begin
      step();
      check("t4_hold_valid", 64'(tx_valid), 64'd1);
      check("t4_hold_id", 64'(tx_id), 64'd0);
      check("t4_hold_data", 64'(tx_data), 64'(pat(0)));
      check("t4_hold_ack", 64'(core_ack), 64'd0);
    end
    check("t4_busy_hold", 64'(busy), 64'd1);
    tx_ready = 1'b1;
    wait_done("t4", 30);
    check("t4_nack", 64'(ack_log.size()), 64'd3);
    check("t4_nhs", 64'(hs_ids.size()), 64'd3);
    for (int k = 0; k < hs_ids.size(); k++) check("t4_hs_order", 64'(hs_ids[k]), 64'(k));
    check("t4_trials", 64'(trials_done), 64'd3);

    // Abort while a result is pending and five trials remain.
    new_test(2, 20, 20, 20, 4'b0001, 1'b0);
    kick(10);
    repeat (9) step();
    check("t5_pre_valid", 64'(tx_valid), 64'd1);
    check("t5_pre_starts", 64'(start_log.size()), 64'd5);
    check("t5_pre_trials", 64'(trials_done), 64'd2);
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    check("t5_valid", 64'(tx_valid), 64'd0);
    check("t5_clear", 64'(core_clear), 64'd1);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_done", 64'(done), 64'd0);
    check("t5_trials", 64'(trials_done), 64'd2);
    check("t5_starts", 64'(start_log.size()), 64'd5);
    step();
    check("t5_clear_pulse", 64'(core_clear), 64'd0);
    check("t5_idle", 64'(busy), 64'd0);
    check("t5_ndone", 64'(n_done - d0), 64'd0);
    new_test(3, 3, 3, 3, 4'b0000, 1'b1);
    kick(2);
    wait_done("t5b", 40);
    check("t5b_nstart", 64'(start_log.size()), 64'd2);
    if (start_log.size() > 0) check("t5b_first", 64'(start_log[0]), 64'd0);
    check("t5b_trials", 64'(trials_done), 64'd2);
    check("t5b_ndone", 64'(n_done - d0), 64'd1);

    // Stray start mid-run and core_done on a FREE core are both ignored.
    new_test(4, 4, 4, 4, 4'b0000, 1'b1);
    kick(6);
    step();
    inj_done = 4'b1000;
    step();
    num_init = 99;
    start    = 1'b1;
    step();
    start    = 1'b0;
    wait_done("t6", 100);
    check("t6_nstart", 64'(start_log.size()), 64'd6);
    check("t6_trials", 64'(trials_done), 64'd6);
    repeat (3) step();
    check("t6_ndone", 64'(n_done - d0), 64'd1);
    check("t6_busy", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/life_sched.md
# life_sched

Trial scheduler and result arbiter between `uart_rx`, NCORE search cores and `uart_tx`. It dispatches `num_init` single-trial jobs round-robin to idle cores and collects hit results. It forwards one result at a time to the transmitter over a valid/ready handshake, then signals batch completion. It replaces the direct core↔uart wiring whenever more than one core is instantiated.

## Interface
- `NCORE`, 4: number of search cores (2..16).
- `DW`, 432: result word width (INIT*INIT+32 for INIT=20).
- `IW`, 4: core index width, ≥ clog2(NCORE).

- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse from uart_rx `run`; honoured only in IDLE.
- `abort` in 1: level from uart_rx `break`; highest priority.
- `num_init` in 32: trial count, sampled on accepted `start`.
- `core_start` out NCORE: one-hot single-cycle trial launch.
- `core_done` in NCORE: single-cycle pulse, trial finished.
- `core_hit` in NCORE: qualifies `core_done`; result held by core until acked.
- `core_data` in NCORE*DW: per-core result, slice i = bits [i*DW +: DW].
- `core_ack` out NCORE: one-hot pulse, result of core i copied.
- `core_clear` out 1: single-cycle pulse, cores drop current trial.
- `tx_valid` out 1: result available.
- `tx_data` out DW: result word.
- `tx_id` out IW: originating core.
- `tx_ready` in 1: transmitter accepts when `tx_valid & tx_ready`.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: single-cycle batch-complete pulse.
- `trials_done` out 32: `core_done` pulses since last accepted `start`.

## Operation
- Per-core state, 2 bits: FREE, RUNNING, HOLD (hit pending).
- FSM states: IDLE, RUN, DRAIN.
- **IDLE**
  - On `start`: load `left`←`num_init`, clear `trials_done`, clear both round-robin pointers, go to RUN.
- **RUN**
  - Each cycle with `left`≠0 and ≥1 FREE core, pick the FREE core at or after `disp_ptr` (wrapping).
  - Pulse its `core_start`, mark it RUNNING, decrement `left`, set `disp_ptr` = chosen index + 1 mod NCORE.
  - Go to DRAIN when `left`==0.
- **DRAIN**
  - Go to IDLE with `done` pulse when all cores are FREE and the output register is empty (handshake complete).
- **Core completion** (RUN and DRAIN)
  - `core_done[i]` on a RUNNING core: increment `trials_done` (saturating at 2^32−1).
  - Core goes to HOLD if `core_hit[i]`, else FREE.
  - `core_done` on a non-RUNNING core is ignored.
- **Result arbitration**
  - When the output register is empty, or emptying this cycle (`tx_valid & tx_ready`), pick the HOLD core at or after `res_ptr`.
  - Load `tx_data`←slice, `tx_id`←index; pulse `core_ack`; core goes to FREE; `res_ptr` advances past it.
- `num_init`=0: RUN immediately goes to DRAIN, so `done` comes 2 cycles after `start` and no `core_start` is issued.
- `start` outside IDLE is ignored.
- **Abort** (any state)
  - Next edge: state IDLE, all cores FREE, output register cleared (`tx_valid`=0 even mid-handshake).
  - `core_clear` pulses; no `done`.
  - `left` and `trials_done` are frozen.
  - `start` is ignored while `abort` is high.

## Timing
- Reset values: every output 0; state IDLE; pointers 0.
- `start` at edge t → RUN at t+1; first `core_start` in cycle t+1 (registered output, visible after edge t+1).
- Dispatch: ≤1 `core_start` per cycle. A core freed by `core_done` at edge t is eligible at t+1.
- Result path:
  - `core_done&core_hit` at t → HOLD at t+1.
  - `tx_valid`, `core_ack` at t+2 if the output register is free.
  - Back-to-back results reach `tx_valid` continuously at full throughput.
- `tx_data`/`tx_id` are stable while `tx_valid & !tx_ready`.
- `done` asserts the cycle after the last handshake / last FREE transition.
- Simultaneous events in one cycle: `core_done[i]` with dispatch to another core is allowed. Core i cannot be both dispatched and acked.

## Structure
- Package `life_sched_pkg`:
  - FSM state enum.
  - Per-core state enum FREE/RUNNING/HOLD.
  - `clog2` function.
- Sub-module `rr_arb` (parameter N): inputs `req[N]`, `ptr`; outputs one-hot `gnt` and `gnt_idx`. Combinational rotate-priority; instantiated twice (dispatch, results).

## Test plan
- NCORE=4, `num_init`=10, every trial done 5 cycles after start, no hits → `core_start` order 0,1,2,3,0,…; `trials_done`=10; one `done` pulse; `tx_valid` never asserts.
- `num_init`=0 → `done` 2 cycles after `start`; no `core_start`.
- Cores 1 and 3 hit in the same cycle, `tx_ready`=1 → `tx_id` 1 then 3 on consecutive cycles; `core_ack` one-hot each; `tx_data` = respective slices.
- `tx_ready` held low 20 cycles with 3 cores in HOLD → `tx_data`/`tx_id` stable; no extra `core_ack`; after release, 3 handshakes, then `done`.
- `abort` asserted while `tx_valid`=1 and `left`=5 → next cycle: `tx_valid`=0, `core_clear` pulse, `busy`=0, no `done`; new `start` then runs normally.
- `start` pulsed mid-RUN and `core_done` on a FREE core → ignored; counters unchanged.
